mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8-input result multiplexer (8:1 mux built from two enabled 4:1 halves).
- Up to eight requesters compete for the mux. The block grants one requester at a time and drives the 3-bit mux select (s0, s1, s2) to match the granted input.
- It holds the grant until the requester releases it or a hold timeout expires.
- It sits between the datapath requesters (ALU, shifter, memory read, immediate paths, etc.) and the mux select lines.

---
 rtl/mux_rr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter and sequencer for the shared 8:1 result multiplexer
// (built from two enabled 4:1 halves). Up to eight datapath requesters
// compete for the mux; one is granted at a time and the encoded grant index
// drives the mux select lines s0..s2.
//
// A grant is held until the owner raises done, the owner drops its request,
// or the grant has lasted MAX_HOLD cycles (forced release, timeout pulse).
// Every release is followed by exactly one IDLE cycle so the mux select has
// a settle/bubble cycle before the next owner's data is used.
//
// Ports:
//   clk      in   1     rising-edge clock
//   reset    in   1     asynchronous, active-high reset
//   req      in   NREQ  request vector, bit i requests mux input Ii
//   done     in   1     release strobe from current owner (GRANT only)
//   grant    out  NREQ  one-hot grant, all zero while idle
//   sel      out  SELW  encoded grant index (sel[0]=s0, sel[1]=s1, sel[2]=s2)
//   busy     out  1     high while a grant is active
//   timeout  out  1     one-cycle pulse after a MAX_HOLD forced release
//
// All outputs are registered. sel keeps its last value while idle; only
// grant and busy clear on release.
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int NREQ     = 8,   // fixed at 8 to match the 8:1 mux
  parameter int SELW     = 3,   // log2(NREQ)
  parameter int MAX_HOLD = 15,  // 1..255
  parameter int CNTW     = 8    // 2^CNTW > MAX_HOLD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [CNTW-1:0] MAX_HOLD_C = CNTW'(MAX_HOLD);
  localparam logic [CNTW-1:0] CNT_ZERO   = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE    = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [SELW-1:0] SEL_ZERO   = {SELW{1'b0}};
  localparam logic [SELW-1:0] SEL_ONE    = {{(SELW-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] GNT_ZERO   = {NREQ{1'b0}};
  localparam logic [NREQ-1:0] GNT_ONE    = {{(NREQ-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Round-robin search: returns {found, index} of the first set bit of r when
  // scanning p, p+1, ... modulo NREQ. The index adder is SELW bits wide, so
  // the wrap from 7 back to 0 falls out of the natural overflow. Scanning from
  // the farthest offset down lets the nearest hit overwrite the rest, which
  // keeps the loop free of early exits.
  // ---------------------------------------------------------------------------
  function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SELW-1:0] p);
    logic [SELW:0]   res;
    logic [SELW-1:0] idx;
    res = {1'b0, SEL_ZERO};
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = p + SELW'(i);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Binary index to one-hot grant vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SELW-1:0] idx);
    return GNT_ONE << idx;
  endfunction

  // State and registered outputs.
  state_e          state_q,   state_d;
  logic [SELW-1:0] ptr_q,     ptr_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  logic [NREQ-1:0] grant_q,   grant_d;
  logic [SELW-1:0] sel_q,     sel_d;
  logic            busy_q,    busy_d;
  logic            timeout_q, timeout_d;

  // Arbitration and release decode.
  logic [SELW:0]   pick_s;
  logic            pick_valid_s;
  logic [SELW-1:0] pick_idx_s;
  logic            owner_req_s;
  logic            hold_expired_s;
  logic            release_s;
  logic            forced_s;

  assign pick_s         = rr_pick(req, ptr_q);
  assign pick_valid_s   = pick_s[SELW];
  assign pick_idx_s     = pick_s[SELW-1:0];

  // While in GRANT, sel_q is the owner index.
  assign owner_req_s    = req[sel_q];
  assign hold_expired_s = (cnt_q == MAX_HOLD_C);
  assign release_s      = done | ~owner_req_s | hold_expired_s;

  // Timeout only when the hold limit is the sole cause: the owner still wants
  // the mux and did not signal done, so the limit must have fired.
  assign forced_s       = ~done & owner_req_s;

  // Next-state and next-output logic for the IDLE/GRANT sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          state_d = S_GRANT;
          grant_d = idx_to_onehot(pick_idx_s);
          sel_d   = pick_idx_s;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          // sel deliberately keeps its last value while idle.
          grant_d = GNT_ZERO;
          busy_d  = 1'b0;
          cnt_d   = CNT_ZERO;
        end
      end

      S_GRANT: begin
        if (release_s) begin
          state_d   = S_IDLE;
          grant_d   = GNT_ZERO;
          busy_d    = 1'b0;
          cnt_d     = CNT_ZERO;
          // Releasing owner drops to lowest priority.
          ptr_d     = sel_q + SEL_ONE;
          timeout_d = forced_s;
        end else begin
          // Other request bits are ignored; grant and sel stay stable.
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = GNT_ZERO;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State register; async reset clears grant immediately without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= SEL_ZERO;
      cnt_q     <= CNT_ZERO;
      grant_q   <= GNT_ZERO;
      sel_q     <= SEL_ZERO;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mux_rr_arbiter: directed scenarios with literal expectations
// followed by randomized request/done traffic, all compared every cycle
// against a behavioural model of the round-robin rules.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int NREQ     = 8;
  localparam int SELW     = 3;
  localparam int MAX_HOLD = 15;
  localparam int CNTW     = 8;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model: owner index (-1 when idle), grant length so far,
  // priority pointer, last select value, timeout pulse.
  int m_owner;
  int m_len;
  int m_ptr;
  int m_sel;
  bit m_timeout;

  // Property trackers on observed DUT behaviour.
  int wait_cnt [NREQ];
  int run_len;
  bit prev_busy;

  mux_rr_arbiter #(
    .NREQ(NREQ), .SELW(SELW), .MAX_HOLD(MAX_HOLD), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_len     = 0;
    m_ptr     = 0;
    m_sel     = 0;
    m_timeout = 1'b0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    run_len   = 0;
    prev_busy = 1'b0;
  endtask

  // Apply the arbitration rules for one rising edge with the sampled inputs.
  task automatic model_edge(input logic [NREQ-1:0] r, input logic d);
    int w;
    w = -1;
    if (m_owner < 0) begin
      m_timeout = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--)
        if (r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_len   = 1;
      end
    end else if (d || !r[m_owner] || m_len == MAX_HOLD) begin
      m_timeout = !d && r[m_owner];
      m_ptr     = (m_owner + 1) % NREQ;
      m_owner   = -1;
    end else begin
      m_len++;
      m_timeout = 1'b0;
    end
  endtask

  function automatic logic [NREQ-1:0] exp_grant();
    if (m_owner < 0) return 8'h00;
    return 8'h01 << m_owner;
  endfunction

  // One clock: sample inputs, advance model, compare just after the edge.
  task automatic step();
    logic [NREQ-1:0] r_s;
    logic            d_s;
    int              g;
    int              maxw;
    r_s = req;
    d_s = done;
    @(posedge clk);
    model_edge(r_s, d_s);
    #1;
    chk("grant",   grant,   exp_grant());
    chk("sel",     sel,     m_sel);
    chk("busy",    busy,    (m_owner >= 0));
    chk("timeout", timeout, m_timeout);
    chk("onehot",  ($countones(grant) <= 1), 1'b1);
    if (busy) chk("sel_matches_grant", grant, (8'h01 << sel));

    if (busy) begin
      run_len++;
    end else begin
      if (prev_busy) chk("hold_len_le_max", (run_len <= MAX_HOLD), 1'b1);
      run_len = 0;
    end

    for (int i = 0; i < NREQ; i++)
      if (!r_s[i]) wait_cnt[i] = 0;
    if (busy && !prev_busy) begin
      g    = int'(sel);
      maxw = 0;
      for (int i = 0; i < NREQ; i++)
        if (r_s[i] && i != g) wait_cnt[i]++;
      wait_cnt[g] = 0;
      for (int i = 0; i < NREQ; i++)
        if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
      chk("starvation_le_7", (maxw <= 7), 1'b1);
    end
    prev_busy = busy;
  endtask

  // Assert reset away from clock edges; outputs must clear without an edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_grant",   grant,   8'h00);
    chk("rst_sel",     sel,     3'd0);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_timeout", timeout, 1'b0);
    model_reset();
    req  = 8'h00;
    done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] e;
    reset = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Single requester held: grant after one cycle, forced release at MAX_HOLD.
    req = 8'h04;
    step();
    chk("t1_grant", grant, 8'h04);
    chk("t1_sel",   sel,   3'd2);
    chk("t1_busy",  busy,  1'b1);
    repeat (MAX_HOLD - 1) step();
    chk("t1_still_granted", grant, 8'h04);
    step();
    chk("t1_release_grant", grant,   8'h00);
    chk("t1_timeout_pulse", timeout, 1'b1);
    chk("t1_sel_holds",     sel,     3'd2);

    // ptr=3 now: wrap search skips 3..7 and lands on 0, then 2.
    req = 8'h05;
    step();
    chk("t3_wrap_grant", grant,   8'h01);
    chk("t3_timeout_lo", timeout, 1'b0);
    done = 1'b1;
    step();
    chk("t3_release", grant, 8'h00);
    done = 1'b0;
    step();
    chk("t3_next_grant", grant, 8'h04);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();

    // All requesting, done after each grant: strict rotation with bubbles.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k <= NREQ; k++) begin
      step();
      e = 8'h01 << (k % NREQ);
      chk("t2_rot_grant", grant, e);
      chk("t2_rot_sel",   sel,   (k % NREQ));
      done = 1'b1;
      step();
      chk("t2_bubble", busy, 1'b0);
      done = 1'b0;
    end

    // Owner drops request mid-grant: no timeout, search resumes after it.
    do_reset();
    req = 8'h60;
    step();
    chk("t4_grant5", grant, 8'h20);
    step();
    step();
    req = 8'h41;
    step();
    chk("t4_drop_release", grant,   8'h00);
    chk("t4_drop_no_to",   timeout, 1'b0);
    step();
    chk("t4_next_from6", grant, 8'h40);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();

    // done coincides with the hold limit: normal release, no timeout.
    do_reset();
    req = 8'h01;
    step();
    repeat (MAX_HOLD - 1) step();
    done = 1'b1;
    step();
    chk("t5_release",    grant,   8'h00);
    chk("t5_no_timeout", timeout, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();

    // Reset mid-grant clears outputs before the next edge.
    do_reset();
    req = 8'h08;
    step();
    chk("t6_grant3", sel, 3'd3);
    step();
    do_reset();

    // Randomized traffic with slowly changing requests.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 199) == 0) req = 8'h00;
      done = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
